// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS core's PC sequencing logic.
//   RESET_VECTOR_DEFAULT : boot address loaded on reset
//   HALT_ADDR_DEFAULT    : control-transfer target that stops the core
//   WORD_BYTES           : instruction size in bytes (sequential PC step)
//   pc_state_t           : sequencer state encoding
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES           = 32'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/mips_cpu_branch_target.sv
// Combinational control-transfer target select for the PC sequencer.
// Ports:
//   pc_i           current instruction address
//   imm_i          branch word offset (instruction[15:0])
//   instr_index_i  J/JAL index (instruction[25:0])
//   rs_data_i      register rs value (JR/JALR target)
//   branch_i       conditional branch present
//   cond_true_i    ALU branch condition
//   jump_i         J/JAL present
//   jump_reg_i     JR/JALR present
//   target_o       selected target address
//   taken_o        control transfer will occur after the delay slot
module mips_cpu_branch_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] rs_data_i,
  input  logic        branch_i,
  input  logic        cond_true_i,
  input  logic        jump_i,
  input  logic        jump_reg_i,
  output logic [31:0] target_o,
  output logic        taken_o
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc_plus4  = pc_i + WORD_BYTES;
  // Word offset sign-extended and scaled to bytes.
  assign br_offset = {{14{imm_i[15]}}, imm_i, 2'b00};
  assign br_target = pc_plus4 + br_offset;
  // J-type target lives in the 256 MB region of the delay-slot instruction.
  assign j_target  = {pc_plus4[31:28], instr_index_i, 2'b00};

  always_comb begin
    target_o = br_target;
    taken_o  = 1'b0;
    if (jump_reg_i) begin
      target_o = rs_data_i;
      taken_o  = 1'b1;
    end else if (jump_i) begin
      target_o = j_target;
      taken_o  = 1'b1;
    end else if (branch_i && cond_true_i) begin
      target_o = br_target;
      taken_o  = 1'b1;
    end
  end

endmodule

// File: rtl/mips_cpu_pc_sequencer.sv
// Program-counter sequencer with a one-instruction branch delay slot.
// Owns the PC, the pending redirect target and the halt flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RUN    | sequential fetch; a taken transfer latches its target
//   DELAY  | executing the delay-slot instruction; target pending
//   HALTED | control reached HALT_ADDR; frozen until reset
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   stall             hold all state this cycle
//   branch, cond_true conditional branch and its ALU condition
//   jump, jump_reg    J/JAL and JR/JALR strobes
//   instr_index, imm  instruction fields for jump/branch targets
//   rs_data           JR/JALR target
//   pc                address of the executing instruction
//   link_addr         pc+8 return address
//   delay_slot        current instruction is a delay-slot instruction
//   active            1 = running, 0 = halted
module mips_cpu_pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        cond_true,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        delay_slot,
  output logic        active
);

  pc_state_t   state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        delay_slot_q;
  logic        active_q;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        taken;

  assign pc_plus4 = pc_q + WORD_BYTES;

  mips_cpu_branch_target u_branch_target (
    .pc_i          (pc_q),
    .imm_i         (imm),
    .instr_index_i (instr_index),
    .rs_data_i     (rs_data),
    .branch_i      (branch),
    .cond_true_i   (cond_true),
    .jump_i        (jump),
    .jump_reg_i    (jump_reg),
    .target_o      (target),
    .taken_o       (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      target_q     <= '0;
      delay_slot_q <= 1'b0;
      active_q     <= 1'b1;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          pc_q <= pc_plus4;
          if (taken) begin
            target_q     <= target;
            state_q      <= DELAY;
            delay_slot_q <= 1'b1;
          end
        end
        DELAY: begin
          // Transfer requests seen during the delay slot are ignored.
          pc_q         <= target_q;
          delay_slot_q <= 1'b0;
          if (target_q == HALT_ADDR) begin
            state_q  <= HALTED;
            active_q <= 1'b0;
          end else begin
            state_q <= RUN;
          end
        end
        HALTED: begin
          pc_q <= HALT_ADDR;
        end
        default: begin
          state_q      <= RUN;
          delay_slot_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign link_addr  = pc_q + 32'd8;
  assign delay_slot = delay_slot_q;
  assign active     = active_q;

endmodule
